qpi_dsm_write_ctrl: RTL
=======================

QPI_DSM_WRITE_CTRL -- requirements
Module: qpi_dsm_write_ctrl

Interface
REQ-001 SHALL have parameter AFU_ID, default 128'h0, the 128-bit AFU identifier written to DSM line 0.
REQ-002 SHALL have parameter N_STAT, default 2, the number of status requesters (fixed 2 in this revision).
REQ-003 SHALL have port clk  input  1  the single clock for all logic.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port csr  input  afu_csr_t  the CSR state: afu_dsm_base, afu_dsm_base_valid, afu_en.
REQ-006 SHALL have port tx_almost_full  input  1  TX write channel backpressure.
REQ-007 SHALL have port tx_wr_valid  output  1  write request strobe, one cycle per request.
REQ-008 SHALL have port tx_wr_addr  output  58  cache-line address of the write.
REQ-009 SHALL have port tx_wr_data  output  512  write payload.
REQ-010 SHALL have port rx_wr_ack  input  1  write-completion pulse, one per issued write, in order.
REQ-011 SHALL have port stat_req  input  2  per-requester status-write request, level.
REQ-012 SHALL have port stat_data  input  2x32  per-requester status word.
REQ-013 SHALL have port stat_grant  output  2  one-hot pulse when that request is accepted.
REQ-014 SHALL have port afu_ready  output  1  high once the AFU ID is committed to the DSM.

Function
REQ-015 SHALL implement states IDLE, WR_ID, WAIT_ID, READY, WR_STAT, WAIT_STAT.
REQ-016 IDLE->WR_ID SHALL occur when csr.afu_dsm_base_valid and csr.afu_en are both 1.
REQ-017 In WR_ID, the block SHALL assert tx_wr_valid for exactly one cycle when tx_almost_full=0, then go to WAIT_ID.
REQ-018 The ID write SHALL use addr = afu_dsm_base[63:6] and data = {384'b0, AFU_ID}.
REQ-019 WAIT_ID->READY SHALL occur on rx_wr_ack, and afu_ready SHALL be 1 from the following cycle.
REQ-020 In READY with any stat_req bit set, the block SHALL grant one requester, round-robin, and enter WR_STAT.
REQ-021 The round-robin pointer SHALL favour the requester not granted last; after reset it SHALL favour requester 0.
REQ-022 With both requests simultaneous, the requester at the pointer SHALL win and the pointer SHALL toggle.
REQ-023 stat_grant[i] SHALL pulse in the same cycle stat_data[i] is captured into a 32-bit holding register.
REQ-024 The status write for requester i SHALL use addr = afu_dsm_base[63:6] + 1 + i (58-bit wrap) and data = {480'b0, held word}.
REQ-025 WR_STAT SHALL issue under the same backpressure rule as WR_ID, then WAIT_STAT->READY on rx_wr_ack.
REQ-026 At most one write SHALL be outstanding at any time.
REQ-027 If afu_en falls in READY, the block SHALL go to IDLE and clear afu_ready in the next cycle.
REQ-028 If afu_en falls in WR_*, the block SHALL abandon the unissued write and go to IDLE without a grant.
REQ-029 If afu_en falls in WAIT_*, the block SHALL wait for rx_wr_ack and then go to IDLE.
REQ-030 rx_wr_ack outside WAIT_* SHALL be ignored.
REQ-031 stat_grant SHALL be 0 outside READY.

Reset
REQ-032 On reset, state SHALL be IDLE, and tx_wr_valid, stat_grant and afu_ready SHALL be 0.
REQ-033 On reset, the RR pointer SHALL be 0, tx_wr_addr and tx_wr_data SHALL be 0, and the holding register SHALL be 0.
REQ-034 Reset asserted mid-write SHALL drop the outstanding write with no recovery.

Structure
REQ-035 The state enum, DSM line offsets (ID=0, STAT_BASE=1) and the write-request struct SHALL live in the shared qpi package beside afu_csr_t.
REQ-036 The 2-way round-robin arbiter SHALL be a sub-module named qpi_rr_arb2.

Verification
REQ-037 Program base=0x1000, set en=1, ack after 5 cycles -> one write, addr 0x40, data[127:0]=AFU_ID, afu_ready=1 one cycle after the ack.
REQ-038 Hold tx_almost_full=1 for 10 cycles in WR_ID -> no tx_wr_valid; a single write in the cycle after almost_full drops.
REQ-039 In READY, assert stat_req=2'b11 with data A5A5A5A5/5A5A5A5A -> grant 0 first (addr 0x41), then grant 1 (addr 0x42), each after the prior ack.
REQ-040 Drop en while in WAIT_STAT -> no new write; IDLE after the ack; afu_ready=0.
REQ-041 Assert reset mid-WAIT_ID -> all outputs 0 immediately; re-init produces a fresh ID write.
REQ-042 Set base=0xFFFF_FFFF_FFFF_FFC0 and issue stat 1 -> addr wraps to 58'h1.

Source files
------------

// File: rtl/qpi_dsm_write_ctrl_pkg.sv
// Shared QPI types for the DSM write controller: CSR view, FSM states,
// DSM line offsets and the write-request bundle.
package qpi_dsm_write_ctrl_pkg;

    localparam int CL_ADDR_W = 58;
    localparam int CL_DATA_W = 512;

    localparam logic [CL_ADDR_W-1:0] DSM_ID_OFFSET = 58'd0;
    localparam logic [CL_ADDR_W-1:0] DSM_STAT_BASE = 58'd1;

    typedef struct packed {
        logic [63:0] afu_dsm_base;
        logic        afu_dsm_base_valid;
        logic        afu_en;
    } afu_csr_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_ID,
        WAIT_ID,
        READY,
        WR_STAT,
        WAIT_STAT
    } dsm_state_e;

    typedef struct packed {
        logic                 valid;
        logic [CL_ADDR_W-1:0] addr;
        logic [CL_DATA_W-1:0] data;
    } wr_req_t;

    // Cache-line address of a DSM entry; the add wraps naturally at 58 bits.
    function automatic logic [CL_ADDR_W-1:0] dsm_line(
        input logic [CL_ADDR_W-1:0] baseLine,
        input logic [CL_ADDR_W-1:0] offset
    );
        return baseLine + offset;
    endfunction

endpackage

// File: rtl/qpi_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer favours the
// requester that was not granted last.
module qpi_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (accept_i && (grant_o != 2'b00)) begin
            ptr_d = grant_o[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/qpi_dsm_write_ctrl.sv
// Writes the AFU ID to DSM line 0 after enable, then serialises status
// words from two requesters into the following DSM lines, one write at a time.
module qpi_dsm_write_ctrl
    import qpi_dsm_write_ctrl_pkg::*;
#(
    parameter logic [127:0] AFU_ID = 128'h0,
    parameter int           N_STAT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  afu_csr_t               csr,
    input  logic                   tx_almost_full,
    output logic                   tx_wr_valid,
    output logic [CL_ADDR_W-1:0]   tx_wr_addr,
    output logic [CL_DATA_W-1:0]   tx_wr_data,
    input  logic                   rx_wr_ack,
    input  logic [N_STAT-1:0]      stat_req,
    input  logic [N_STAT-1:0][31:0] stat_data,
    output logic [N_STAT-1:0]      stat_grant,
    output logic                   afu_ready
);

    dsm_state_e           state_q;
    wr_req_t              wrReq_q;
    logic                 afuReady_q;
    logic [31:0]          holdWord_q;
    logic                 statSel_q;
    logic [1:0]           arbReq;
    logic [1:0]           arbGrant;
    logic [CL_ADDR_W-1:0] baseLine;
    logic                 unusedCsrBits;

    assign baseLine      = csr.afu_dsm_base[63:6];
    assign unusedCsrBits = ^csr.afu_dsm_base[5:0];

    // Requests are only visible to the arbiter while idle-ready and enabled,
    // so a grant always coincides with the capture into the holding register.
    assign arbReq = (state_q == READY && csr.afu_en) ? stat_req : 2'b00;

    qpi_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    (arbReq),
        .accept_i (|arbGrant),
        .grant_o  (arbGrant)
    );

    assign stat_grant  = arbGrant;
    assign tx_wr_valid = wrReq_q.valid;
    assign tx_wr_addr  = wrReq_q.addr;
    assign tx_wr_data  = wrReq_q.data;
    assign afu_ready   = afuReady_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wrReq_q    <= '0;
            afuReady_q <= 1'b0;
            holdWord_q <= '0;
            statSel_q  <= 1'b0;
        end else begin
            wrReq_q.valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (csr.afu_dsm_base_valid && csr.afu_en) begin
                        state_q <= WR_ID;
                    end
                end
                WR_ID: begin
                    if (!csr.afu_en) begin
                        state_q <= IDLE;
                    end else if (!tx_almost_full) begin
                        wrReq_q.valid <= 1'b1;
                        wrReq_q.addr  <= dsm_line(baseLine, DSM_ID_OFFSET);
                        wrReq_q.data  <= {384'b0, AFU_ID};
                        state_q       <= WAIT_ID;
                    end
                end
                WAIT_ID: begin
                    if (rx_wr_ack) begin
                        if (csr.afu_en) begin
                            state_q    <= READY;
                            afuReady_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                READY: begin
                    if (!csr.afu_en) begin
                        state_q    <= IDLE;
                        afuReady_q <= 1'b0;
                    end else if (|arbGrant) begin
                        holdWord_q <= arbGrant[1] ? stat_data[1] : stat_data[0];
                        statSel_q  <= arbGrant[1];
                        state_q    <= WR_STAT;
                    end
                end
                WR_STAT: begin
                    if (!csr.afu_en) begin
                        state_q    <= IDLE;
                        afuReady_q <= 1'b0;
                    end else if (!tx_almost_full) begin
                        wrReq_q.valid <= 1'b1;
                        wrReq_q.addr  <= dsm_line(baseLine,
                                                  DSM_STAT_BASE + {57'b0, statSel_q});
                        wrReq_q.data  <= {480'b0, holdWord_q};
                        state_q       <= WAIT_STAT;
                    end
                end
                WAIT_STAT: begin
                    if (rx_wr_ack) begin
                        if (csr.afu_en) begin
                            state_q <= READY;
                        end else begin
                            state_q    <= IDLE;
                            afuReady_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
